// File: rtl/ascii_varies_arbiter.sv
// Round-robin writer arbiter for the ASCII overlay value bank. Writes land in a
// shadow bank and are copied to the displayed bank only at frame end.
`ifndef OV5640_X
`define OV5640_X 640
`endif
`ifndef OV5640_Y
`define OV5640_Y 480
`endif

module ascii_varies_arbiter #(
  parameter int N_REQ       = 4,
  parameter int N_SLOT_USED = 7,
  parameter int FRAME_X     = `OV5640_X,
  parameter int FRAME_Y     = `OV5640_Y
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 i_pix_valid,
  input  logic                 i_freeze,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [N_REQ*4-1:0]   i_slot,
  input  logic [N_REQ*8-1:0]   i_value,
  output logic [N_REQ-1:0]     o_ack,
  output logic [127:0]         o_varies,
  output logic                 o_commit,
  output logic                 o_pending
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int XW = (FRAME_X > 1) ? $clog2(FRAME_X) : 1;
  localparam int YW = (FRAME_Y > 1) ? $clog2(FRAME_Y) : 1;
  localparam logic [PW-1:0] PTR_RST  = PW'(N_REQ - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(FRAME_X - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(FRAME_Y - 1);
  localparam logic [4:0]    SLOT_LIM = 5'(N_SLOT_USED);

  // Two-digit display: anything above 99 saturates.
  function automatic logic [7:0] clamp99(input logic [7:0] v);
    if (v > 8'd99) begin
      return 8'd99;
    end else begin
      return v;
    end
  endfunction

  logic [PW-1:0]       ptr_q, ptr_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic [15:0][7:0]    shadow_q, shadow_d;
  logic [15:0][7:0]    active_q, active_d;
  logic                pending_q, pending_d;
  logic                commit_q, commit_d;
  logic [XW-1:0]       cnt_x_q, cnt_x_d;
  logic [YW-1:0]       cnt_y_q, cnt_y_d;

  logic [N_REQ-1:0]    eligible_s;
  logic                grant_s;
  logic [PW-1:0]       grant_idx_s;
  logic [PW-1:0]       cand_s;
  logic [3:0]          slot_s;
  logic [7:0]          value_s;
  logic                wr_ok_s;
  logic                frame_end_s;
  logic                commit_s;

  assign slot_s      = i_slot[{grant_idx_s, 2'b00} +: 4];
  assign value_s     = i_value[{grant_idx_s, 3'b000} +: 8];
  assign frame_end_s = i_pix_valid && (cnt_x_q == X_LAST) && (cnt_y_q == Y_LAST);

  // Round-robin search starting one past the last grant; acked requesters are masked.
  always_comb begin
    eligible_s  = i_req & ~ack_q;
    grant_s     = 1'b0;
    grant_idx_s = ptr_q;
    cand_s      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_s = PW'((int'(ptr_q) + i) % N_REQ);
      if (!grant_s && eligible_s[cand_s]) begin
        grant_s     = 1'b1;
        grant_idx_s = cand_s;
      end else begin
      end
    end
  end

  // Next state: shadow write, frame-end commit, pixel counters.
  always_comb begin
    ptr_d    = ptr_q;
    ack_d    = '0;
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_x_d  = cnt_x_q;
    cnt_y_d  = cnt_y_q;
    wr_ok_s  = 1'b0;

    if (grant_s) begin
      ack_d = N_REQ'(1'b1) << grant_idx_s;
      ptr_d = grant_idx_s;
      if ({1'b0, slot_s} < SLOT_LIM) begin
        shadow_d[slot_s] = clamp99(value_s);
        wr_ok_s          = 1'b1;
      end else begin
        wr_ok_s = 1'b0;
      end
    end else begin
      ack_d = '0;
    end

    // Commit copies the pre-edge shadow, so a coincident write waits a frame.
    commit_s = frame_end_s && pending_q && !i_freeze;
    commit_d = commit_s;
    if (commit_s) begin
      active_d  = shadow_q;
      pending_d = wr_ok_s;
    end else begin
      pending_d = pending_q | wr_ok_s;
    end

    if (i_pix_valid) begin
      if (cnt_x_q == X_LAST) begin
        cnt_x_d = '0;
        if (cnt_y_q == Y_LAST) begin
          cnt_y_d = '0;
        end else begin
          cnt_y_d = cnt_y_q + 1'b1;
        end
      end else begin
        cnt_x_d = cnt_x_q + 1'b1;
      end
    end else begin
      cnt_x_d = cnt_x_q;
    end
  end

  // State registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ptr_q     <= PTR_RST;
      ack_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      commit_q  <= 1'b0;
      cnt_x_q   <= '0;
      cnt_y_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      ack_q     <= ack_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      commit_q  <= commit_d;
      cnt_x_q   <= cnt_x_d;
      cnt_y_q   <= cnt_y_d;
    end
  end

  assign o_ack     = ack_q;
  assign o_varies  = active_q;
  assign o_commit  = commit_q;
  assign o_pending = pending_q;

endmodule

// File: tb/tb_ascii_varies_arbiter.sv
// Directed bench for ascii_varies_arbiter with a small frame (4x2) and
// scoreboard queues for expected acks and committed banks.
module tb_ascii_varies_arbiter;

  logic         sys_clk;
  logic         sys_rst_n;
  logic         i_pix_valid;
  logic         i_freeze;
  logic [3:0]   i_req;
  logic [15:0]  i_slot;
  logic [31:0]  i_value;
  logic [3:0]   o_ack;
  logic [127:0] o_varies;
  logic         o_commit;
  logic         o_pending;

  ascii_varies_arbiter #(
    .N_REQ(4), .N_SLOT_USED(7), .FRAME_X(4), .FRAME_Y(2)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_pix_valid(i_pix_valid),
    .i_freeze(i_freeze), .i_req(i_req), .i_slot(i_slot), .i_value(i_value),
    .o_ack(o_ack), .o_varies(o_varies), .o_commit(o_commit), .o_pending(o_pending)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int passed = 0;
  int total  = 0;

  logic [3:0]       ack_sb[$];
  logic [127:0]     var_sb[$];
  logic [15:0][7:0] exp_shadow;
  logic [15:0][7:0] exp_active;
  logic             exp_pend;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic chk_ack(input string tag);
    logic [3:0] e;
    if (ack_sb.size() > 0) e = ack_sb.pop_front();
    else e = 4'bxxxx;
    chk(tag, {124'd0, o_ack}, {124'd0, e});
  endtask

  task automatic chk_var(input string tag);
    logic [127:0] e;
    if (var_sb.size() > 0) e = var_sb.pop_front();
    else e = 128'bx;
    chk(tag, o_varies, e);
  endtask

  task automatic model_write(input int slot, input int val);
    logic [7:0] v;
    v = 8'(val);
    if (slot < 7) begin
      exp_shadow[slot] = (v > 8'd99) ? 8'd99 : v;
      exp_pend = 1'b1;
    end
  endtask

  task automatic drive_req(input int k, input int slot, input int val);
    i_req[k] = 1'b1;
    i_slot[k*4 +: 4]  = 4'(slot);
    i_value[k*8 +: 8] = 8'(val);
    ack_sb.push_back(4'b0001 << k);
  endtask

  task automatic do_write(input string tag, input int k, input int slot, input int val);
    drive_req(k, slot, val);
    model_write(slot, val);
    tick();
    chk_ack({tag, "_ack"});
    chk({tag, "_pending"}, {127'd0, o_pending}, {127'd0, exp_pend});
    i_req[k] = 1'b0;
  endtask

  // Eight pixel strobes; the last one is frame_end. Optional write on that edge.
  task automatic frame(input string tag, input bit do_wr, input int k, input int slot, input int val);
    logic commit_exp;
    i_pix_valid = 1'b1;
    repeat (7) tick();
    commit_exp = exp_pend && !i_freeze;
    if (commit_exp) begin
      exp_active = exp_shadow;
      exp_pend   = 1'b0;
    end
    var_sb.push_back(exp_active);
    if (do_wr) begin
      drive_req(k, slot, val);
      model_write(slot, val);
    end
    tick();
    i_pix_valid = 1'b0;
    chk({tag, "_commit"}, {127'd0, o_commit}, {127'd0, commit_exp});
    chk({tag, "_pending"}, {127'd0, o_pending}, {127'd0, exp_pend});
    chk_var({tag, "_varies"});
    if (do_wr) begin
      chk_ack({tag, "_ack"});
      i_req[k] = 1'b0;
    end
    tick();
    chk({tag, "_commit_end"}, {127'd0, o_commit}, 128'd0);
  endtask

  initial begin
    sys_rst_n = 1'b0; i_pix_valid = 1'b0; i_freeze = 1'b0;
    i_req = 4'd0; i_slot = 16'd0; i_value = 32'd0;
    exp_shadow = '0; exp_active = '0; exp_pend = 1'b0;
    tick(); tick();
    sys_rst_n = 1'b1;
    chk("rst_ack", {124'd0, o_ack}, 128'd0);
    chk("rst_varies", o_varies, 128'd0);
    chk("rst_pending", {127'd0, o_pending}, 128'd0);
    chk("rst_commit", {127'd0, o_commit}, 128'd0);

    // Contention, out-of-range slots: acks rotate 0,1,2,3,0, nothing pending.
    i_slot = {4'd12, 4'd11, 4'd10, 4'd9};
    i_value = 32'h0B0A_0908;
    i_req = 4'hF;
    ack_sb.push_back(4'b0001); ack_sb.push_back(4'b0010);
    ack_sb.push_back(4'b0100); ack_sb.push_back(4'b1000);
    ack_sb.push_back(4'b0001);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_ack($sformatf("rr_ack%0d", c));
    end
    i_req = 4'h0;
    tick();
    chk("rr_idle_ack", {124'd0, o_ack}, 128'd0);
    chk("rr_pending", {127'd0, o_pending}, 128'd0);

    // Single write then commit.
    do_write("w42", 0, 2, 42);
    frame("f42", 1'b0, 0, 0, 0);
    chk("slot2_is_42", {120'd0, o_varies[23:16]}, 128'd42);

    // Clamp to 99.
    do_write("w200", 1, 1, 200);
    frame("f200", 1'b0, 0, 0, 0);
    chk("slot1_is_99", {120'd0, o_varies[15:8]}, 128'd99);

    // Out-of-range slot: acked, discarded, no commit.
    do_write("w9", 2, 9, 77);
    frame("f9", 1'b0, 0, 0, 0);

    // Write coinciding with frame_end lands for the following frame.
    do_write("w3", 0, 0, 3);
    frame("fb1", 1'b1, 0, 0, 5);
    chk("slot0_is_3", {120'd0, o_varies[7:0]}, 128'd3);
    frame("fb2", 1'b0, 0, 0, 0);
    chk("slot0_is_5", {120'd0, o_varies[7:0]}, 128'd5);

    // Freeze holds the display across two frame ends.
    do_write("w55", 3, 4, 55);
    i_freeze = 1'b1;
    frame("fz1", 1'b0, 0, 0, 0);
    frame("fz2", 1'b0, 0, 0, 0);
    i_freeze = 1'b0;
    frame("fz3", 1'b0, 0, 0, 0);
    chk("slot4_is_55", {120'd0, o_varies[39:32]}, 128'd55);

    // Reset in mid-operation with requests held.
    do_write("w7", 1, 5, 7);
    i_slot = {4'd6, 4'd6, 4'd6, 4'd6};
    i_value = 32'h0403_0201;
    i_req = 4'hF;
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("mrst_ack", {124'd0, o_ack}, 128'd0);
    chk("mrst_varies", o_varies, 128'd0);
    chk("mrst_pending", {127'd0, o_pending}, 128'd0);
    chk("mrst_commit", {127'd0, o_commit}, 128'd0);
    exp_shadow = '0; exp_active = '0; exp_pend = 1'b0;
    ack_sb.delete();
    tick();
    chk("mrst_hold_ack", {124'd0, o_ack}, 128'd0);
    sys_rst_n = 1'b1;
    ack_sb.push_back(4'b0001);
    model_write(6, 1);
    tick();
    chk_ack("post_rst_ack");
    i_req = 4'h0;
    frame("fpost", 1'b0, 0, 0, 0);
    chk("slot6_is_1", {120'd0, o_varies[55:48]}, 128'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ascii_varies_arbiter.md
ASCII_VARIES_ARBITER -- requirements
Module: ascii_varies_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of value requesters.
REQ-002 SHALL have parameter N_SLOT_USED, default 7: number of writable display slots (0..N_SLOT_USED-1) out of 16.
REQ-003 SHALL have parameter FRAME_X, default `OV5640_X: active pixels per line.
REQ-004 SHALL have parameter FRAME_Y, default `OV5640_Y: active lines per frame.
REQ-005 SHALL have port sys_clk  input  1  clock; all logic rising-edge.
REQ-006 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_pix_valid  input  1  pixel strobe of the overlay video stream.
REQ-008 SHALL have port i_freeze  input  1  1 = suppress commits, keep displayed values.
REQ-009 SHALL have port i_req  input  N_REQ  per-requester write request, held until acked.
REQ-010 SHALL have port i_slot  input  N_REQ*4  per-requester slot index, requester k at [k*4+:4].
REQ-011 SHALL have port i_value  input  N_REQ*8  per-requester unsigned value, requester k at [k*8+:8].
REQ-012 SHALL have port o_ack  output  N_REQ  one-cycle grant/acknowledge, one-hot or zero.
REQ-013 SHALL have port o_varies  output  128  committed value bank, slot s at [s*8+:8], drives the ASCII overlay.
REQ-014 SHALL have port o_commit  output  1  one-cycle pulse: o_varies updated.
REQ-015 SHALL have port o_pending  output  1  shadow bank holds uncommitted writes.

Function
REQ-016 SHALL keep a 16x8 shadow bank and a 16x8 active bank; o_varies = active bank, registered.
REQ-017 SHALL arbitrate round-robin: eligible = i_req & ~o_ack; search starts at requester (last_grant+1) mod N_REQ; pointer resets to N_REQ-1 so requester 0 has first priority.
REQ-018 SHALL grant at most one requester per cycle; on the grant edge write shadow[slot] and set o_ack[k]=1 for exactly the next cycle (latency 1 from request seen to ack).
REQ-019 SHALL mask a requester while its o_ack bit is 1, so a held request is never written twice; requester drops i_req in the ack cycle, or a re-held request is a new write 2 cycles later.
REQ-020 SHALL clamp written values: i_value > 99 stores 99 (two-digit display); 0..99 stored unchanged.
REQ-021 SHALL ack but discard writes with slot >= N_SLOT_USED; discarded writes do not set o_pending.
REQ-022 SHALL count i_pix_valid with cnt_x 0..FRAME_X-1 and cnt_y 0..FRAME_Y-1, both wrapping to 0; frame_end = i_pix_valid at cnt_x=FRAME_X-1, cnt_y=FRAME_Y-1.
REQ-023 SHALL commit on the frame_end edge when o_pending=1 and i_freeze=0: active <= shadow (pre-edge contents), o_pending <= 0, o_commit=1 next cycle only.
REQ-024 SHALL, when a valid write coincides with frame_end commit, land the write in shadow only and leave o_pending=1 for the next frame.
REQ-025 SHALL leave active bank, o_pending unchanged at frame_end when i_freeze=1 or o_pending=0; o_commit stays 0.
REQ-026 SHALL never change o_varies except on a commit edge, so the display is stable for a whole frame.
REQ-027 SHALL set o_pending=1 on any accepted in-range write.

Reset
REQ-028 SHALL on sys_rst_n=0 asynchronously clear shadow, active, o_varies, o_ack, o_commit, o_pending, cnt_x, cnt_y; set arbitration pointer to N_REQ-1.
REQ-029 SHALL drop any in-flight request at reset; requesters re-issue after release; no ack is issued for a request pending during reset.

Verification
REQ-030 Single write: req0 slot 2 value 42 -> o_ack=4'b0001 one cycle later, o_pending=1; after frame_end o_commit pulse, o_varies[23:16]=42.
REQ-031 Contention: req0..3 held continuously -> acks rotate 0,1,2,3,0 with one ack per cycle, no requester acked on consecutive cycles.
REQ-032 Clamp/range: value 200 to slot 1 -> o_varies[15:8]=99 after commit; write to slot 9 (N_SLOT_USED=7) -> acked, o_pending stays 0, o_varies unchanged.
REQ-033 Boundary: write to slot 0 value 5 on frame_end cycle with prior pending slot 0=3 -> commit shows 3, o_pending=1, next frame_end shows 5.
REQ-034 Freeze: i_freeze=1 across two frame_ends with pending writes -> no o_commit, o_varies constant; freeze released -> commit at next frame_end.
REQ-035 Reset mid-operation: assert sys_rst_n=0 with req active and o_pending=1 -> all outputs 0 immediately; after release, req0 granted first.
